// File: rtl/decode_queue_wide_pkg.sv
// Shared types for the wide decode queue.
//   fetch_entry_t : one raw fetched instruction as it sits in the queue
//   uop_t         : decoded micro-op handed to rename
//   opcode_t      : decoded operation class
// M_WIDTH / LG_PHT_SZ mirror the machine-wide address and PHT-index widths.
package decode_queue_wide_pkg;

    localparam int M_WIDTH   = 32;
    localparam int LG_PHT_SZ = 8;
    localparam int LG_ROB    = 5;

    typedef enum logic [3:0] {
        OP_II      = 4'd0,   // illegal / unsupported
        OP_ADDI    = 4'd1,
        OP_ADDIW   = 4'd2,
        OP_ADDU    = 4'd3,
        OP_SUBU    = 4'd4,
        OP_LUI     = 4'd5,
        OP_BEQ     = 4'd6,
        OP_BNE     = 4'd7,
        OP_JAL     = 4'd8,
        OP_JALR    = 4'd9,
        OP_LW      = 4'd10,
        OP_SW      = 4'd11,
        OP_RDCYCLE = 4'd12
    } opcode_t;

    typedef struct packed {
        logic [31:0]          insn;
        logic [M_WIDTH-1:0]   pc;
        logic                 pred;
        logic [LG_PHT_SZ-1:0] pht_idx;
        logic [M_WIDTH-1:0]   pred_target;
    } fetch_entry_t;

    typedef struct packed {
        opcode_t              op;
        logic [4:0]           srcA;
        logic [4:0]           srcB;
        logic [4:0]           dst;
        logic                 has_dst;
        logic [31:0]          imm;
        logic [M_WIDTH-1:0]   pc;
        logic                 pred;
        logic [LG_PHT_SZ-1:0] pht_idx;
        logic [M_WIDTH-1:0]   pred_target;
        logic [LG_ROB-1:0]    rob_ptr;
        logic                 serializing_op;
    } uop_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_queue_wide_decode.sv
// Single-instruction RISC-V decoder (one per output lane).
//   mode64_i : RV64 enable; gates the W-suffixed ops
//   entry_i  : queued fetch entry
//   uop_o    : decoded uop; sideband (pc, prediction) copied through, rob_ptr left 0
module decode_riscv
    import decode_queue_wide_pkg::*;
(
    input  logic         mode64_i,
    input  fetch_entry_t entry_i,
    output uop_t         uop_o
);

    logic [31:0] insn;
    uop_t        u;

    assign insn = entry_i.insn;

    always_comb begin
        u             = '0;
        u.pc          = entry_i.pc;
        u.pred        = entry_i.pred;
        u.pht_idx     = entry_i.pht_idx;
        u.pred_target = entry_i.pred_target;
        case (insn[6:0])
            7'h13: if (insn[14:12] == 3'b000) begin
                u.op = OP_ADDI; u.srcA = insn[19:15]; u.dst = insn[11:7];
                u.imm = sext12(insn[31:20]);
            end
            7'h1b: if (mode64_i && insn[14:12] == 3'b000) begin
                u.op = OP_ADDIW; u.srcA = insn[19:15]; u.dst = insn[11:7];
                u.imm = sext12(insn[31:20]);
            end
            7'h33: if (insn[14:12] == 3'b000 && (insn[31:25] == 7'h00 || insn[31:25] == 7'h20)) begin
                u.op = (insn[30]) ? OP_SUBU : OP_ADDU;
                u.srcA = insn[19:15]; u.srcB = insn[24:20]; u.dst = insn[11:7];
            end
            7'h37: begin
                u.op = OP_LUI; u.dst = insn[11:7]; u.imm = {insn[31:12], 12'h000};
            end
            7'h63: if (insn[14:13] == 2'b00) begin
                u.op = (insn[12]) ? OP_BNE : OP_BEQ;
                u.srcA = insn[19:15]; u.srcB = insn[24:20];
                u.imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            7'h6f: begin
                u.op = OP_JAL; u.dst = insn[11:7];
                u.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            7'h67: if (insn[14:12] == 3'b000) begin
                u.op = OP_JALR; u.srcA = insn[19:15]; u.dst = insn[11:7];
                u.imm = sext12(insn[31:20]);
            end
            7'h03: if (insn[14:12] == 3'b010) begin
                u.op = OP_LW; u.srcA = insn[19:15]; u.dst = insn[11:7];
                u.imm = sext12(insn[31:20]);
            end
            7'h23: if (insn[14:12] == 3'b010) begin
                u.op = OP_SW; u.srcA = insn[19:15]; u.srcB = insn[24:20];
                u.imm = sext12({insn[31:25], insn[11:7]});
            end
            7'h73: begin
                // Every SYSTEM-class op drains alone; only rdcycle is decoded further.
                u.serializing_op = 1'b1;
                if (insn[14:12] == 3'b010 && insn[19:15] == 5'd0 && insn[31:20] == 12'hc00) begin
                    u.op = OP_RDCYCLE; u.dst = insn[11:7];
                end
            end
            default: ;
        endcase
        u.has_dst = (u.dst != 5'd0);
        uop_o     = u;
    end

endmodule

// File: rtl/decode_queue_wide.sv
// Multi-lane decode queue between fetch and rename.
//   clk, reset_n   : clock, synchronous active-low reset
//   flush          : drop everything queued and presented
//   mode64         : RV64 decode enable
//   in_*           : W_IN-wide fetch bundle, in_valid contiguous from lane 0
//   in_ready       : room for a full W_IN bundle (registered)
//   out_valid/uop  : registered W_OUT-wide decoded bundle
//   out_ready      : rename takes the whole bundle
//   occupancy      : raw entries held
module decode_queue_wide
    import decode_queue_wide_pkg::*;
#(
    parameter int W_IN  = 2,
    parameter int W_OUT = 2,
    parameter int DEPTH = 8
)
(
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 flush,
    input  logic                                 mode64,
    input  logic [W_IN-1:0]                      in_valid,
    input  logic [W_IN-1:0][31:0]                in_insn,
    input  logic [W_IN-1:0][M_WIDTH-1:0]         in_pc,
    input  logic [W_IN-1:0]                      in_pred,
    input  logic [W_IN-1:0][LG_PHT_SZ-1:0]       in_pht_idx,
    input  logic [W_IN-1:0][M_WIDTH-1:0]         in_pred_target,
    output logic                                 in_ready,
    output logic [W_OUT-1:0]                     out_valid,
    output uop_t [W_OUT-1:0]                     out_uop,
    input  logic                                 out_ready,
    output logic [$clog2(DEPTH):0]               occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    fetch_entry_t          mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  in_ready_q, in_ready_d;
    logic [W_OUT-1:0]      out_valid_q, out_valid_d;
    uop_t [W_OUT-1:0]      out_uop_q, out_uop_d;
    uop_t [W_OUT-1:0]      dec_uop;
    logic [OW-1:0]         enq_cnt, fill_n, n_eff;
    logic                  fill_stop;
    logic                  load;

    // Lane k decodes the entry at head+k; entries beyond occupancy are ignored by the fill logic.
    for (genvar k = 0; k < W_OUT; k++) begin : g_lane
        decode_riscv u_dec (
            .mode64_i (mode64),
            .entry_i  (mem_q[head_q + PW'(k)]),
            .uop_o    (dec_uop[k])
        );
    end

    always_comb begin
        enq_cnt = '0;
        if (in_ready_q && !flush) begin
            for (int i = 0; i < W_IN; i++) begin
                if (in_valid[i]) enq_cnt = enq_cnt + OW'(1);
            end
        end
    end

    // Fill count: stop at the queue end, stop before a serializing op in lane k>0,
    // and let a serializing op in lane 0 go out by itself.
    always_comb begin
        fill_n    = '0;
        fill_stop = 1'b0;
        for (int k = 0; k < W_OUT; k++) begin
            if (!fill_stop) begin
                if (OW'(k) >= occ_q) begin
                    fill_stop = 1'b1;
                end else if (k != 0 && dec_uop[k].serializing_op) begin
                    fill_stop = 1'b1;
                end else begin
                    fill_n = OW'(k + 1);
                    if (dec_uop[k].serializing_op) fill_stop = 1'b1;
                end
            end
        end
    end

    assign load = ~|out_valid_q | out_ready;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_uop_d   = out_uop_q;
        n_eff       = '0;
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            occ_d       = '0;
            out_valid_d = '0;
            out_uop_d   = '0;
        end else begin
            n_eff  = load ? fill_n : '0;
            tail_d = tail_q + PW'(enq_cnt);
            head_d = head_q + PW'(n_eff);
            occ_d  = occ_q + enq_cnt - n_eff;
            if (load) begin
                for (int k = 0; k < W_OUT; k++) begin
                    out_valid_d[k] = (OW'(k) < fill_n);
                    out_uop_d[k]   = (OW'(k) < fill_n) ? dec_uop[k] : '0;
                end
            end
        end
        in_ready_d = (OW'(DEPTH) - occ_d) >= OW'(W_IN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= '0;
            out_uop_q   <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_uop_q   <= out_uop_d;
        end
    end

    // Queue storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < W_IN; i++) begin
            if (OW'(i) < enq_cnt) begin
                mem_q[tail_q + PW'(i)].insn        <= in_insn[i];
                mem_q[tail_q + PW'(i)].pc          <= in_pc[i];
                mem_q[tail_q + PW'(i)].pred        <= in_pred[i];
                mem_q[tail_q + PW'(i)].pht_idx     <= in_pht_idx[i];
                mem_q[tail_q + PW'(i)].pred_target <= in_pred_target[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_uop   = out_uop_q;
    assign occupancy = occ_q;

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n) occ_q <= OW'(DEPTH));
    a_enq_ready: assert property (@(posedge clk) disable iff (!reset_n) (enq_cnt != '0) |-> in_ready_q);
    a_in_contig: assert property (@(posedge clk) disable iff (!reset_n)
                                  (in_valid & (in_valid + W_IN'(1))) == '0);
    a_out_contig: assert property (@(posedge clk) disable iff (!reset_n)
                                   (out_valid_q & (out_valid_q + W_OUT'(1))) == '0);

endmodule
